// File: rtl/register_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled WIDTH-bit register among REQS
// requesters. Each load is a one-cycle strobe. An optional gap of GAP idle
// cycles follows every load.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for any request; picks the winner at the next edge
// S_LOAD   | one-cycle grant/load strobe; q captures d_out at closing edge
// S_SETTLE | quiet gap after a load; requests ignored until count hits 0
module register_load_arbiter #(
    parameter  int WIDTH = 3,
    parameter  int REQS  = 4,
    parameter  int GAP   = 1,
    localparam int OW    = $clog2(REQS),
    localparam int CW    = (GAP > 1) ? $clog2(GAP) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [REQS-1:0]         i_req,
    input  logic [REQS*WIDTH-1:0]   i_din,
    output logic [REQS-1:0]         o_gnt,
    output logic                    o_load_out,
    output logic [WIDTH-1:0]        o_d_out,
    output logic [OW-1:0]           o_owner,
    output logic [WIDTH-1:0]        o_q,
    output logic                    o_valid
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE} state_t;

    state_t             r_state, w_state_n;
    logic [REQS-1:0]    r_gnt, w_gnt_n;
    logic               r_load, w_load_n;
    logic [WIDTH-1:0]   r_d, w_d_n;
    logic [OW-1:0]      r_owner, w_owner_n;
    logic [WIDTH-1:0]   r_q, w_q_n;
    logic               r_valid, w_valid_n;
    logic [OW-1:0]      r_ptr, w_ptr_n;
    logic [CW-1:0]      r_cnt, w_cnt_n;

    logic               w_found;
    logic [OW-1:0]      w_winner;
    logic [WIDTH-1:0]   w_din [REQS];

    // Unpack the flattened data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < REQS; i++) begin
            w_din[i] = i_din[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting at the pointer, wrapping at REQS-1.
    always_comb begin : p_arb
        int            idx;
        logic [OW-1:0] sel;
        idx      = 0;
        sel      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < REQS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= REQS) idx = idx - REQS;
            sel = OW'(idx);
            if (!w_found && i_req[sel]) begin
                w_found  = 1'b1;
                w_winner = sel;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n = r_state;
        w_gnt_n   = r_gnt;
        w_load_n  = r_load;
        w_d_n     = r_d;
        w_owner_n = r_owner;
        w_q_n     = r_q;
        w_valid_n = r_valid;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_n   = '0;
                    w_gnt_n[w_winner] = 1'b1;
                    w_load_n  = 1'b1;
                    w_d_n     = w_din[w_winner];
                    w_owner_n = w_winner;
                    w_ptr_n   = (w_winner == OW'(REQS-1)) ? '0 : w_winner + 1'b1;
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                w_q_n     = r_d;
                w_valid_n = 1'b1;
                w_gnt_n   = '0;
                w_load_n  = 1'b0;
                if (GAP > 0) begin
                    w_cnt_n   = CW'(GAP - 1);
                    w_state_n = S_SETTLE;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_load  <= 1'b0;
            r_d     <= '0;
            r_owner <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_load  <= w_load_n;
            r_d     <= w_d_n;
            r_owner <= w_owner_n;
            r_q     <= w_q_n;
            r_valid <= w_valid_n;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_load_out = r_load;
    assign o_d_out    = r_d;
    assign o_owner    = r_owner;
    assign o_q        = r_q;
    assign o_valid    = r_valid;

endmodule

// File: tb/tb_register_load_arbiter.sv
// Bench for register_load_arbiter: a GAP=1/REQS=4 instance and a GAP=0/REQS=3
// instance. Expected grants are queued when requests are driven and popped
// when the DUT strobes a load.
module tb_register_load_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [2:0] d;
        logic [1:0] owner;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req1 = '0;
    logic [11:0] din1 = '0;
    logic [3:0]  gnt1;
    logic        load1;
    logic [2:0]  d1, q1;
    logic [1:0]  own1;
    logic        valid1;
    logic [2:0]  req0 = '0;
    logic [8:0]  din0 = '0;
    logic [2:0]  gnt0;
    logic        load0;
    logic [2:0]  d0, q0;
    logic [1:0]  own0;
    logic        valid0;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    register_load_arbiter #(.WIDTH(3), .REQS(4), .GAP(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_din(din1),
        .o_gnt(gnt1), .o_load_out(load1), .o_d_out(d1), .o_owner(own1),
        .o_q(q1), .o_valid(valid1));

    register_load_arbiter #(.WIDTH(3), .REQS(3), .GAP(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_din(din0),
        .o_gnt(gnt0), .o_load_out(load0), .o_d_out(d0), .o_owner(own0),
        .o_q(q0), .o_valid(valid0));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req1 = '0; req0 = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req1 = 4'b1111; req0 = 3'b111; din1 = 12'o7777;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (gnt1 !== 4'b0) $display("FAIL rst_gnt got=%b exp=0000", gnt1); else n_pass++;
            n_total++; if (load1 !== 1'b0) $display("FAIL rst_load got=%b exp=0", load1); else n_pass++;
            n_total++; if (q1 !== 3'd0) $display("FAIL rst_q got=%0d exp=0", q1); else n_pass++;
            n_total++; if (valid1 !== 1'b0) $display("FAIL rst_valid got=%b exp=0", valid1); else n_pass++;
            n_total++; if (own1 !== 2'd0) $display("FAIL rst_owner got=%0d exp=0", own1); else n_pass++;
        end
        req1 = '0; req0 = '0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        din1 = {3'd0, 3'd0, 3'd5, 3'd0};
        req1 = 4'b0010;
        sbq.push_back('{gnt: 4'b0010, d: 3'd5, owner: 2'd1});
        tick();
        e = sbq.pop_front();
        n_total++; if (load1 !== 1'b1) $display("FAIL single_load got=%b exp=1", load1); else n_pass++;
        n_total++; if (gnt1 !== e.gnt) $display("FAIL single_gnt got=%b exp=%b", gnt1, e.gnt); else n_pass++;
        n_total++; if (d1 !== e.d) $display("FAIL single_dout got=%0d exp=%0d", d1, e.d); else n_pass++;
        n_total++; if (own1 !== e.owner) $display("FAIL single_owner got=%0d exp=%0d", own1, e.owner); else n_pass++;
        req1 = '0;
        tick();
        n_total++; if (q1 !== 3'd5) $display("FAIL single_q got=%0d exp=5", q1); else n_pass++;
        n_total++; if (valid1 !== 1'b1) $display("FAIL single_valid got=%b exp=1", valid1); else n_pass++;
        n_total++; if (gnt1 !== 4'b0 || load1 !== 1'b0) $display("FAIL single_drop got=%b/%b exp=0000/0", gnt1, load1); else n_pass++;
        // request arrives during SETTLE: must be ignored until IDLE
        req1 = 4'b0001;
        sbq.push_back('{gnt: 4'b0001, d: 3'd0, owner: 2'd0});
        tick();
        n_total++; if (load1 !== 1'b0) $display("FAIL settle_ignore got=%b exp=0", load1); else n_pass++;
        tick();
        e = sbq.pop_front();
        n_total++; if (gnt1 !== e.gnt) $display("FAIL settle_regrant got=%b exp=%b", gnt1, e.gnt); else n_pass++;
        req1 = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int last;
        logic [2:0] qexp;
        bit qpend;
        apply_reset();
        din1 = {3'd6, 3'd3, 3'd5, 3'd1};
        sbq.push_back('{gnt: 4'b0001, d: 3'd1, owner: 2'd0});
        sbq.push_back('{gnt: 4'b0010, d: 3'd5, owner: 2'd1});
        sbq.push_back('{gnt: 4'b0100, d: 3'd3, owner: 2'd2});
        sbq.push_back('{gnt: 4'b1000, d: 3'd6, owner: 2'd3});
        sbq.push_back('{gnt: 4'b0001, d: 3'd1, owner: 2'd0});
        req1 = 4'b1111;
        last = -1; qexp = '0; qpend = 1'b0;
        for (int cyc = 0; cyc < 40 && (sbq.size() > 0 || qpend); cyc++) begin
            tick();
            n_total++; if (load1 !== (|gnt1) || !$onehot0(gnt1)) $display("FAIL rr_strobe load=%b gnt=%b exp onehot/match", load1, gnt1); else n_pass++;
            if (qpend) begin
                n_total++; if (q1 !== qexp) $display("FAIL rr_q got=%0d exp=%0d", q1, qexp); else n_pass++;
                qpend = 1'b0;
            end
            if (load1) begin
                e = sbq.pop_front();
                n_total++; if (gnt1 !== e.gnt) $display("FAIL rr_gnt got=%b exp=%b", gnt1, e.gnt); else n_pass++;
                n_total++; if (d1 !== e.d) $display("FAIL rr_dout got=%0d exp=%0d", d1, e.d); else n_pass++;
                n_total++; if (own1 !== e.owner) $display("FAIL rr_owner got=%0d exp=%0d", own1, e.owner); else n_pass++;
                if (last >= 0) begin
                    n_total++; if (cyc - last !== 3) $display("FAIL rr_period got=%0d exp=3", cyc - last); else n_pass++;
                end
                last = cyc; qexp = e.d; qpend = 1'b1;
                if (sbq.size() == 0) req1 = '0;
            end
        end
        n_total++; if (sbq.size() != 0) $display("FAIL rr_timeout left=%0d exp=0", sbq.size()); else n_pass++;
        sbq.delete();
        req1 = '0;
        tick(); tick();
    endtask

    task automatic test_data_stability();
        exp_t e;
        bit bad;
        apply_reset();
        din1 = {3'd0, 3'd3, 3'd0, 3'd0};
        req1 = 4'b0100;
        sbq.push_back('{gnt: 4'b0100, d: 3'd3, owner: 2'd2});
        tick();
        e = sbq.pop_front();
        n_total++; if (gnt1 !== e.gnt) $display("FAIL stab_gnt got=%b exp=%b", gnt1, e.gnt); else n_pass++;
        n_total++; if (d1 !== e.d) $display("FAIL stab_dout got=%0d exp=%0d", d1, e.d); else n_pass++;
        din1 = {3'd0, 3'd7, 3'd0, 3'd0};
        req1 = '0;
        tick();
        n_total++; if (q1 !== 3'd3) $display("FAIL stab_q got=%0d exp=3", q1); else n_pass++;
        n_total++; if (d1 !== 3'd3) $display("FAIL stab_dhold got=%0d exp=3", d1); else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (load1 !== 1'b0 || q1 !== 3'd3) bad = 1'b1;
        end
        n_total++; if (bad) $display("FAIL stab_noreload load=%b q=%0d exp 0/3", load1, q1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        din1 = {3'd0, 3'd0, 3'd6, 3'd0};
        req1 = 4'b0010;
        sbq.push_back('{gnt: 4'b0010, d: 3'd6, owner: 2'd1});
        tick();
        e = sbq.pop_front();
        n_total++; if (d1 !== e.d) $display("FAIL mid_dout got=%0d exp=%0d", d1, e.d); else n_pass++;
        rst_n = 1'b0; req1 = '0;
        tick();
        n_total++; if (q1 !== 3'd0) $display("FAIL mid_q got=%0d exp=0", q1); else n_pass++;
        n_total++; if (valid1 !== 1'b0) $display("FAIL mid_valid got=%b exp=0", valid1); else n_pass++;
        n_total++; if (gnt1 !== 4'b0 || load1 !== 1'b0) $display("FAIL mid_strobe got=%b/%b exp=0000/0", gnt1, load1); else n_pass++;
        n_total++; if (own1 !== 2'd0) $display("FAIL mid_owner got=%0d exp=0", own1); else n_pass++;
        rst_n = 1'b1;
        din1 = {3'd4, 3'd0, 3'd6, 3'd2};
        req1 = 4'b1001;
        sbq.push_back('{gnt: 4'b0001, d: 3'd2, owner: 2'd0});
        tick();
        e = sbq.pop_front();
        n_total++; if (gnt1 !== e.gnt) $display("FAIL mid_ptr_gnt got=%b exp=%b", gnt1, e.gnt); else n_pass++;
        req1 = '0;
        tick();
        n_total++; if (q1 !== 3'd2) $display("FAIL mid_q2 got=%0d exp=2", q1); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_gap0(input logic [2:0] rq, input logic [8:0] dv, input string tag);
        exp_t e;
        int last;
        logic [2:0] qexp;
        bit qpend, prev, consec;
        req0 = rq; din0 = dv;
        last = -1; qexp = '0; qpend = 1'b0; prev = 1'b0; consec = 1'b0;
        for (int cyc = 0; cyc < 30 && (sbq.size() > 0 || qpend); cyc++) begin
            tick();
            if (prev && load0) consec = 1'b1;
            prev = load0;
            if (qpend) begin
                n_total++; if (q0 !== qexp) $display("FAIL %s_q got=%0d exp=%0d", tag, q0, qexp); else n_pass++;
                qpend = 1'b0;
            end
            if (load0) begin
                e = sbq.pop_front();
                n_total++; if ({1'b0, gnt0} !== e.gnt) $display("FAIL %s_gnt got=%b exp=%b", tag, gnt0, e.gnt[2:0]); else n_pass++;
                n_total++; if (d0 !== e.d) $display("FAIL %s_dout got=%0d exp=%0d", tag, d0, e.d); else n_pass++;
                n_total++; if (own0 !== e.owner) $display("FAIL %s_owner got=%0d exp=%0d", tag, own0, e.owner); else n_pass++;
                if (last >= 0) begin
                    n_total++; if (cyc - last !== 2) $display("FAIL %s_period got=%0d exp=2", tag, cyc - last); else n_pass++;
                end
                last = cyc; qexp = e.d; qpend = 1'b1;
                if (sbq.size() == 0) req0 = '0;
            end
        end
        n_total++; if (sbq.size() != 0) $display("FAIL %s_timeout left=%0d exp=0", tag, sbq.size()); else n_pass++;
        n_total++; if (consec) $display("FAIL %s_consecutive got=1 exp=0", tag); else n_pass++;
        sbq.delete();
        req0 = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_data_stability();
        test_reset_mid();
        apply_reset();
        sbq.push_back('{gnt: 4'b0100, d: 3'd4, owner: 2'd2});
        sbq.push_back('{gnt: 4'b0100, d: 3'd4, owner: 2'd2});
        sbq.push_back('{gnt: 4'b0100, d: 3'd4, owner: 2'd2});
        test_gap0(3'b100, {3'd4, 3'd0, 3'd0}, "gap0");
        sbq.push_back('{gnt: 4'b0001, d: 3'd5, owner: 2'd0});
        sbq.push_back('{gnt: 4'b0010, d: 3'd2, owner: 2'd1});
        sbq.push_back('{gnt: 4'b0100, d: 3'd7, owner: 2'd2});
        sbq.push_back('{gnt: 4'b0001, d: 3'd5, owner: 2'd0});
        test_gap0(3'b111, {3'd7, 3'd2, 3'd5}, "wrap3");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/register_load_arbiter.md
Name: register_load_arbiter

Overview:
Round-robin controller that shares one load-enabled WIDTH-bit register among REQS requesters. It accepts load requests, picks one winner per slot, drives the register's load/data strobe for exactly one cycle and holds the stored value on q. An optional programmable quiet gap separates successive loads. It sits between several producer blocks and a single shared configuration/data register.

Parameters:
WIDTH, 3, data width of the shared register
REQS, 4, number of requesters (>=2)
GAP, 1, idle cycles inserted after each load (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req  input  REQS  per-requester load request, level, held until granted
din  input  REQS*WIDTH  flattened data; requester i at din[i*WIDTH +: WIDTH]
gnt  output  REQS  one-hot grant, registered, high only during LOAD cycle
load_out  output  1  load strobe to register, high only during LOAD cycle
d_out  output  WIDTH  data captured from winner, stable during LOAD
owner  output  clog2(REQS)  index of last granted requester
q  output  WIDTH  shared register contents
valid  output  1  high once q has been loaded at least once since reset

Behaviour:
- Reset is synchronous, active-low, sampled on clk rising edge. While rst_n=0 at an edge, the following are set: state=IDLE, gnt=0, load_out=0, d_out=0, owner=0, q=0, valid=0, round-robin pointer ptr=0, gap counter=0.
- FSM states are IDLE, LOAD and SETTLE.
- IDLE: at an edge with |req=1, choose the first set req bit searching ptr, ptr+1, ... modulo REQS. Then register gnt=onehot(winner), load_out=1, d_out=din[winner], owner=winner and ptr=(winner+1) mod REQS, and go to LOAD. With req=0, stay in IDLE and keep all outputs.
- LOAD lasts exactly 1 cycle. At its closing edge: q<=d_out, valid<=1, gnt<=0, load_out<=0. Next state is SETTLE with count=GAP-1 if GAP>0, else IDLE.
- SETTLE: decrement count each edge; go to IDLE at the edge where count==0. req is ignored in SETTLE.
- Load period under continuous demand is GAP+2 cycles.
- Latency: req seen in IDLE at edge k gives gnt/load_out high in cycle k..k+1, and q updated at edge k+1.
- din is sampled only at the grant edge. Changes during LOAD/SETTLE do not affect d_out or q.
- Requester protocol: deassert req at the first edge after gnt is observed. A req still high when IDLE is re-entered counts as a new request.
- Fairness: the winner gets lowest priority next round. A sole requester is re-granted every GAP+2 cycles.
- gnt is always zero or one-hot. load_out==|gnt at all times.
- ptr wraps REQS-1 -> 0. Non-power-of-2 REQS must wrap correctly. owner never exceeds REQS-1.
- Reset during LOAD: q is not loaded with d_out. All outputs take reset values at that edge.
- Reset during SETTLE aborts the gap.

Test Plan:
1. Reset with rst_n=0 for 2 edges, req=1111 -> gnt=0, load_out=0, q=0, valid=0, owner=0 throughout reset.
2. Single request, GAP=1: req=0010, din[1]=5 -> one edge later gnt=0010, load_out=1, d_out=5, owner=1; next edge q=5, valid=1, gnt=0; then 1 SETTLE cycle, then IDLE.
3. Round-robin, GAP=1: req=1111 held, din={r3=6,r2=3,r1=5,r0=1} -> grants 0001, 0010, 0100, 1000, 0001 spaced 3 cycles apart; q sequence 1, 5, 3, 6, 1; owner 0, 1, 2, 3, 0.
4. Data stability: grant r2 with din[2]=3, then change din[2]=7 during LOAD -> d_out=3 during LOAD, q=3 after, no further load unless r2 re-requests.
5. Reset mid-operation: assert rst_n=0 at the LOAD-closing edge after granting din=6 -> q=0 (not 6), valid=0, state IDLE. Re-request afterwards is granted starting search at r0.
6. GAP=0 build: req=0100 held, din[2]=4 -> gnt pulses every 2 cycles, q=4, load_out never high on consecutive cycles.
